// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle 16x16 -> 32-bit shift-add multiplier that borrows
// the shared 16-bit ALU one iteration per granted cycle.
// Optional feature: define MUL_SIGNED_EN to enable two's-complement multiply
// (adds the FIXA/FIXB correction states when signed_op is set at start).
// Without the macro signed_op is ignored and every multiply is unsigned.

`ifndef NOP
`define NOP 5'd0
`endif
`ifndef ADD
`define ADD 5'd1
`endif
`ifndef SUB
`define SUB 5'd2
`endif

module alu_mul_seq #(
  parameter int ITER  = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        alu_gnt,
  input  logic [15:0] alu_aluo,
  input  logic        alu_cf,
  output logic        alu_req,
  output logic [4:0]  alu_instruct,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic        alu_cf_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_FIXA = 3'd2,
    S_FIXB = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      acc_hi_q, acc_hi_d;
  logic [15:0]      acc_lo_q, acc_lo_d;
  logic [15:0]      mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef MUL_SIGNED_EN
  // Multiplier is shifted out of acc_lo, so keep a copy for the sign fix.
  logic [15:0]      mplier_q, mplier_d;
  logic             sgn_q, sgn_d;
`else
  logic             unused_signed_op;
  assign unused_signed_op = signed_op;
`endif

  // Carry-in is never needed: RUN adds, FIX subtracts with the ALU's own borrow.
  assign alu_cf_in = 1'b0;
  assign product   = {acc_hi_q, acc_lo_q};

  // State and datapath registers; reset clears everything so product reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
`ifdef MUL_SIGNED_EN
      mplier_q <= '0;
      sgn_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
`ifdef MUL_SIGNED_EN
      mplier_q <= mplier_d;
      sgn_q    <= sgn_d;
`endif
    end
  end

  // Next-state, datapath update and ALU drive; nothing moves without a grant.
  always_comb begin
    state_d      = state_q;
    acc_hi_d     = acc_hi_q;
    acc_lo_d     = acc_lo_q;
    mcand_d      = mcand_q;
    cnt_d        = cnt_q;
`ifdef MUL_SIGNED_EN
    mplier_d     = mplier_q;
    sgn_d        = sgn_q;
`endif
    alu_req      = 1'b0;
    alu_instruct = `NOP;
    alu_in1      = '0;
    alu_in2      = '0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_hi_d = '0;
          acc_lo_d = a;
          mcand_d  = b;
          cnt_d    = '0;
`ifdef MUL_SIGNED_EN
          mplier_d = a;
          sgn_d    = signed_op;
`endif
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        busy         = 1'b1;
        alu_req      = 1'b1;
        alu_instruct = `ADD;
        alu_in1      = acc_hi_q;
        alu_in2      = acc_lo_q[0] ? mcand_q : 16'd0;
        if (alu_gnt) begin
          // Carry folds into the shift, keeping acc_hi at 16 bits.
          acc_hi_d = {alu_cf, alu_aluo[15:1]};
          acc_lo_d = {alu_aluo[0], acc_lo_q[15:1]};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER - 1)) begin
`ifdef MUL_SIGNED_EN
            state_d = sgn_q ? S_FIXA : S_DONE;
`else
            state_d = S_DONE;
`endif
          end
        end
      end

      S_FIXA: begin
`ifdef MUL_SIGNED_EN
        // Negative multiplier: its sign bit weighed -2^15, not +2^15.
        busy         = 1'b1;
        alu_req      = 1'b1;
        alu_instruct = `SUB;
        alu_in1      = acc_hi_q;
        alu_in2      = mplier_q[15] ? mcand_q : 16'd0;
        if (alu_gnt) begin
          acc_hi_d = alu_aluo;
          state_d  = S_FIXB;
        end
`else
        state_d = S_IDLE;
`endif
      end

      S_FIXB: begin
`ifdef MUL_SIGNED_EN
        // Negative multiplicand: same correction with the roles swapped.
        busy         = 1'b1;
        alu_req      = 1'b1;
        alu_instruct = `SUB;
        alu_in1      = acc_hi_q;
        alu_in2      = mcand_q[15] ? mplier_q : 16'd0;
        if (alu_gnt) begin
          acc_hi_d = alu_aluo;
          state_d  = S_DONE;
        end
`else
        state_d = S_IDLE;
`endif
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized and directed bench for alu_mul_seq with a
// behavioural ALU and a plain-arithmetic product/latency reference.

`ifndef NOP
`define NOP 5'd0
`endif
`ifndef ADD
`define ADD 5'd1
`endif
`ifndef SUB
`define SUB 5'd2
`endif

module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [15:0] a, b;
  logic        alu_gnt;
  logic [15:0] alu_aluo;
  logic        alu_cf;
  logic        alu_req;
  logic [4:0]  alu_instruct;
  logic [15:0] alu_in1, alu_in2;
  logic        alu_cf_in;
  logic        busy, done;
  logic [31:0] product;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .alu_gnt(alu_gnt), .alu_aluo(alu_aluo), .alu_cf(alu_cf),
    .alu_req(alu_req), .alu_instruct(alu_instruct), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_cf_in(alu_cf_in), .busy(busy), .done(done),
    .product(product)
  );

  // Behavioural shared ALU.
  always_comb begin
    {alu_cf, alu_aluo} = 17'd0;
    case (alu_instruct)
      `ADD: {alu_cf, alu_aluo} = {1'b0, alu_in1} + {1'b0, alu_in2} + {16'd0, alu_cf_in};
      `SUB: {alu_cf, alu_aluo} = {1'b0, alu_in1} - {1'b0, alu_in2};
      default: {alu_cf, alu_aluo} = 17'd0;
    endcase
  end

  function automatic logic [31:0] model_prod(input logic [15:0] x, input logic [15:0] y,
                                             input logic sg);
    logic signed [31:0] sx, sy, sp;
    model_prod = {16'd0, x} * {16'd0, y};
`ifdef MUL_SIGNED_EN
    if (sg) begin
      sx = $signed({{16{x[15]}}, x});
      sy = $signed({{16{y[15]}}, y});
      sp = sx * sy;
      model_prod = sp;
    end
`else
    if (sg) model_prod = {16'd0, x} * {16'd0, y};
`endif
  endfunction

  function automatic int model_lat(input logic sg);
`ifdef MUL_SIGNED_EN
    model_lat = sg ? 19 : 17;
`else
    model_lat = sg ? 17 : 17;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one multiply from IDLE, stall the grant in cycles flagged by
  // stall_mask, optionally pulse a stray start in poke_cyc, and report what
  // was observed. Returns one cycle after done (back in IDLE).
  task automatic do_mul(input logic [15:0] ia, input logic [15:0] ib, input logic isg,
                        input logic [63:0] stall_mask, input int poke_cyc,
                        output int done_cyc, output logic [31:0] prod,
                        output int proto_err, output int stall_err,
                        output logic done_next);
    logic [15:0] p1, p2;
    logic        prev_stall;
    done_cyc  = -1;
    prod      = '0;
    proto_err = 0;
    stall_err = 0;
    prev_stall = 1'b0;
    p1 = '0;
    p2 = '0;
    a = ia;
    b = ib;
    signed_op = isg;
    start = 1'b1;
    alu_gnt = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (prev_stall && (alu_in1 !== p1 || alu_in2 !== p2)) stall_err++;
      if (busy !== (done === 1'b1 ? 1'b0 : 1'b1)) proto_err++;
      if (alu_cf_in !== 1'b0) proto_err++;
      if (done === 1'b1) begin
        done_cyc = c;
        prod = product;
        start = 1'b0;
        alu_gnt = 1'b1;
        break;
      end
      prev_stall = stall_mask[c];
      p1 = alu_in1;
      p2 = alu_in2;
      alu_gnt = ~stall_mask[c];
      start = (c == poke_cyc);
      if (c == poke_cyc) a = 16'd7;
    end
    start = 1'b0;
    alu_gnt = 1'b1;
    tick();
    done_next = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    signed_op = 1'b0;
    a = '0;
    b = '0;
    alu_gnt = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: busy=%b done=%b req=%b, want 0 0 0", busy, done, alu_req);
    end
    n_cmp++;
    if (product !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_product: got %h want 00000000", product);
    end
    n_cmp++;
    if (alu_instruct !== `NOP || alu_in1 !== 16'd0 || alu_in2 !== 16'd0 || alu_cf_in !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_alu: instr=%0d in1=%h in2=%h cf_in=%b, want NOP 0 0 0",
               alu_instruct, alu_in1, alu_in2, alu_cf_in);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic check_mul(input string nm, input logic [15:0] ia, input logic [15:0] ib,
                           input logic isg, input logic [63:0] mask, input int poke,
                           input logic [31:0] exp_p, input int exp_c);
    int dc, pe, se;
    logic [31:0] pr;
    logic dn;
    do_mul(ia, ib, isg, mask, poke, dc, pr, pe, se, dn);
    n_cmp++;
    if (pr !== exp_p) begin
      n_bad++;
      $display("FAIL %s_product: a=%h b=%h got %h want %h", nm, ia, ib, pr, exp_p);
    end
    n_cmp++;
    if (dc != exp_c) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d want %0d", nm, dc, exp_c);
    end
    n_cmp++;
    if (pe != 0 || se != 0 || dn !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_protocol: busy/cf_in errs=%0d stall errs=%0d done_after=%b want 0 0 0",
               nm, pe, se, dn);
    end
  endtask

  task automatic test_basic();
    check_mul("basic", 16'd3, 16'd5, 1'b0, 64'd0, -1, 32'h0000000F, 17);
  endtask

  task automatic test_max();
    check_mul("max_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 64'd0, -1, 32'hFFFE0001, 17);
    check_mul("max_8000", 16'h8000, 16'h0002, 1'b0, 64'd0, -1, 32'h00010000, 17);
  endtask

  task automatic test_stall();
    logic [63:0] m;
    m = 64'd0;
    m[5] = 1'b1;
    m[6] = 1'b1;
    m[7] = 1'b1;
    check_mul("stall", 16'h1234, 16'h0010, 1'b0, m, -1, 32'h00012340, 20);
  endtask

  task automatic test_ignored_start();
    check_mul("ignored_start", 16'd11, 16'd13, 1'b0, 64'd0, 4, 32'd143, 17);
  endtask

  task automatic test_abort();
    int ndone;
    a = 16'h00FF;
    b = 16'h00FF;
    signed_op = 1'b0;
    alu_gnt = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 2; i <= 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || product !== 32'd0 || done !== 1'b0 || alu_req !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_state: busy=%b product=%h done=%b req=%b, want 0 0 0 0",
               busy, product, done, alu_req);
    end
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", ndone);
    end
  endtask

  task automatic test_signed();
`ifdef MUL_SIGNED_EN
    check_mul("signed", 16'hFFFE, 16'h0003, 1'b1, 64'd0, -1, 32'hFFFFFFFA, 19);
`else
    check_mul("signed", 16'hFFFE, 16'h0003, 1'b1, 64'd0, -1, 32'h0002FFFA, 17);
`endif
  endtask

  task automatic test_back_to_back();
    check_mul("b2b_first", 16'd7, 16'd9, 1'b0, 64'd0, -1, 32'd63, 17);
    check_mul("b2b_second", 16'd2, 16'd2, 1'b0, 64'd0, -1, 32'h00000004, 17);
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    logic        rs;
    logic [63:0] m;
    int          k;
    for (int n = 0; n < 20; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n == 0) ra = 16'h8000;
      if (n == 1) rb = 16'hFFFF;
      rs = 1'($urandom);
      m = 64'd0;
      k = 0;
      for (int c = 2; c <= 15; c++) begin
        if ($urandom_range(3) == 0) begin
          m[c] = 1'b1;
          k++;
        end
      end
      check_mul($sformatf("rand%0d", n), ra, rb, rs, m, -1,
                model_prod(ra, rb, rs), model_lat(rs) + k);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_stall();
    test_ignored_start();
    test_abort();
    test_signed();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle 16x16 -> 32-bit multiply sequencer built on the shared 16-bit ALU. It performs shift-add multiplication by driving the ALU's opcode, operand and carry-in inputs once per iteration and capturing aluo and cf. It sits beside the execute stage and borrows the ALU only when the pipeline grants it.

Parameters:
ITER, 16, number of shift-add iterations; equals operand width, fixed at 16.
CNT_W, 5, width of the iteration counter; must hold the value ITER.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse requesting a multiply; sampled only in IDLE.
signed_op  in  1  treat a and b as two's complement; honoured only with MUL_SIGNED_EN.
a  in  16  multiplier, captured on an accepted start.
b  in  16  multiplicand, captured on an accepted start.
alu_gnt  in  1  pipeline grants the ALU this cycle.
alu_aluo  in  16  ALU result.
alu_cf  in  1  ALU carry out.
alu_req  out  1  sequencer requests the ALU; high in RUN and FIX states.
alu_instruct  out  5  opcode to the ALU, taken from the shared cpu.v opcode macros.
alu_in1  out  16  ALU operand 1.
alu_in2  out  16  ALU operand 2.
alu_cf_in  out  1  ALU carry in; always 0.
busy  out  1  high from the cycle after an accepted start until DONE.
done  out  1  one-cycle pulse; product is valid in this cycle.
product  out  32  {acc_hi, acc_lo}; holds its value until the next accepted start.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, alu_req=0, product=0, cnt=0, alu_instruct=`NOP, alu_in1=0, alu_in2=0, alu_cf_in=0.
- IDLE: if start=1, capture acc_hi<=0, acc_lo<=a, mcand<=b, sgn<=signed_op, cnt<=0, then go to RUN. If start=0, stay in IDLE.
- RUN: alu_req=1, alu_instruct=`ADD, alu_in1=acc_hi, alu_in2 = acc_lo[0] ? mcand : 0.
  - When alu_gnt=1: acc_hi<={alu_cf, alu_aluo[15:1]}, acc_lo<={alu_aluo[0], acc_lo[15:1]}, cnt<=cnt+1.
  - When cnt reaches ITER-1 on a granted cycle, go to FIXA if MUL_SIGNED_EN is defined and sgn=1; otherwise go to DONE.
  - When alu_gnt=0: all state holds and outputs stay stable (stall).
- FIXA / FIXB: these states exist only with MUL_SIGNED_EN (see Optional Feature).
- DONE: lasts one cycle. done=1, busy=0, alu_req=0, then return to IDLE.
- Outside RUN and FIX states, the ALU outputs are driven with `NOP and zero operands.
- Latency: with alu_gnt held at 1, start in cycle 0 gives RUN in cycles 1-16 and done in cycle 17. Each cycle with alu_gnt=0 adds exactly one cycle.
- start while busy or in DONE is ignored; no queueing.
- rst asserted mid-operation aborts the multiply. All outputs take their reset values in the next cycle and no done is produced.
- Arithmetic: the unsigned result is exact modulo 2^32. acc_hi never exceeds 16 bits because the carry is folded into the shift.

Optional Feature:
Macro MUL_SIGNED_EN.
- Defined, sgn=1: two extra states follow RUN, both gated by alu_gnt.
  - FIXA: if a[15]=1, acc_hi<=acc_hi-b using alu_instruct=`SUB; otherwise acc_hi is unchanged and the state still costs one cycle.
  - FIXB: if b[15]=1, acc_hi<=acc_hi-a using `SUB; otherwise acc_hi is unchanged and the state still costs one cycle.
  - Then go to DONE. Signed latency is 19 cycles; a and b are held internally for this step.
- Defined, sgn=0: latency stays 17 cycles.
- Not defined: signed_op is ignored and all multiplies are unsigned with 17-cycle latency.

Test Plan:
- Basic unsigned: rst, then start with a=3, b=5, alu_gnt=1 -> done in cycle 17, product=0x0000000F; busy high in cycles 1-16.
- Max operands: a=0xFFFF, b=0xFFFF -> product=0xFFFE0001. Also a=0x8000, b=0x0002 -> product=0x00010000.
- Grant stall: a=0x1234, b=0x0010, alu_gnt low for 3 cycles mid-RUN -> done in cycle 20, product=0x00012340; alu_in1 and alu_in2 stable during the stall.
- Ignored start and reset: pulse start while busy with a=7 -> result unaffected. Assert rst in cycle 8 of a run -> busy=0, product=0, no done pulse.
- Signed (MUL_SIGNED_EN): signed_op=1, a=0xFFFE, b=0x0003 -> product=0xFFFFFFFA, done in cycle 19. Same stimulus without the macro -> product=0x0002FFFA, done in cycle 17.
- Back-to-back: start again in the cycle after done with a=2, b=2 -> accepted, product=0x00000004 after 17 more cycles.
